spi_master_drv: RTL and testbench
=================================

Name: spi_master_drv

Overview:
Byte-level SPI master (mode 0, MSB first) that sits directly downstream of the flash command controllers, including the page-program controller. It consumes their spi_start, spi_end and data_send strobes and drives spi_cs_n, spi_sclk and spi_mosi to the W25Qxx flash. It returns one send_done pulse per byte and captures spi_miso so read-side controllers can use the same driver.

Parameters:
CLK_DIV, 2, sys_clk cycles per SCLK half-period (legal 1..255); default gives 12.5 MHz SCLK at 50 MHz.
CS_MIN_HIGH, 3, minimum sys_clk cycles spi_cs_n stays high after a transaction before a new spi_start is accepted.

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
spi_start  in  1  one-cycle pulse: open a transaction; data_send holds the first byte in the same cycle
spi_end  in  1  one-cycle pulse: close the transaction at the next byte boundary
data_send  in  8  byte to transmit; sampled at start and at each byte boundary
send_done  out  1  one-cycle pulse: current byte fully shifted
data_rec  out  8  byte captured from spi_miso; valid from the send_done cycle until the next byte completes
rec_done  out  1  one-cycle pulse, coincident with send_done
spi_busy  out  1  high from accepted spi_start until the CS_MIN_HIGH guard expires
spi_cs_n  out  1  flash chip select, active-low
spi_sclk  out  1  serial clock, idle low
spi_mosi  out  1  serial data out
spi_miso  in  1  serial data in

Behaviour:
- Clocking and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst. All outputs are registered.
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, send_done=0, rec_done=0, data_rec=0, spi_busy=0. State is IDLE, all counters are 0, end_pend=0.
- Reset asserted mid-byte: spi_cs_n returns high at the next edge. No send_done is issued.
- States: IDLE, SETUP, SHIFT, GAP, HOLD, GUARD.
- IDLE
  - spi_start=1 latches data_send into the shift register and moves to SETUP.
  - Next cycle: spi_cs_n=0, spi_mosi=bit7, spi_busy=1.
  - spi_end in IDLE is ignored.
- SETUP: spi_sclk low for CLK_DIV cycles, then SHIFT.
- SHIFT, 8 bits, each bit = CLK_DIV cycles high + CLK_DIV cycles low:
  - Rising edge: sample spi_miso into the receive register LSB and shift left.
  - Falling edge (bits 0..6): present the next MOSI bit.
  - After the 8th falling edge: send_done=1 and rec_done=1 for exactly one cycle (call it T); data_rec is updated in that same cycle T.
  - Byte period, start of SETUP to send_done: 17*CLK_DIV cycles (34 at default).
- GAP (cycle T+1, exactly one cycle): gives the upstream controller one cycle to register its response to send_done.
  - If spi_end=1 in this cycle, or end_pend=1: go to HOLD and clear end_pend.
  - Otherwise: latch data_send, drive spi_mosi=bit7, go to SETUP. The next byte follows without CS deassertion.
- end_pend: set when spi_end=1 in any of SETUP, SHIFT or HOLD; consumed at GAP.
- HOLD: spi_cs_n stays low and spi_sclk stays low for CLK_DIV cycles. Then spi_cs_n=1 and go to GUARD.
- GUARD: spi_cs_n high for CS_MIN_HIGH cycles, spi_busy still 1, then IDLE.
- spi_start while spi_busy=1 is ignored with no side effects. Upstream gaps must exceed HOLD+GUARD; the existing 11-cycle command gap satisfies the defaults.
- spi_start and spi_end high in the same IDLE cycle: the start is taken and the end is latched into end_pend. Result is a single-byte transaction.
- data_send changes outside the IDLE-start and GAP sample cycles have no effect.
- Counters: div_cnt is 8-bit and counts 0..CLK_DIV-1, wrapping to 0 on each SCLK toggle; bit_cnt is 3-bit and counts 0..7.

Decomposition:
- Shared package spi_pkg holds:
  - state enum spi_drv_state_t (IDLE, SETUP, SHIFT, GAP, HOLD, GUARD);
  - flash opcodes: WR_EN=8'h06, PAGE_PROGRAM=8'h02, READ_DATA=8'h03, READ_SR1=8'h05, SECTOR_ERASE=8'h20;
  - default CLK_DIV and CS_MIN_HIGH.
- One natural sub-module, spi_sclk_div: div_cnt plus rise/fall enable pulses, run-enabled by the FSM. The FSM and shift registers stay in spi_master_drv.

Test Plan:
1. Single byte: spi_start with data_send=8'h06, spi_end at T+1 → MOSI shows 0,0,0,0,0,1,1,0 on 8 rising edges; send_done at cycle 34 after SETUP entry; spi_cs_n high CLK_DIV cycles later; spi_busy low after 3 guard cycles.
2. Page-program stream: bytes 02,00,00,00 then data 00,04,...,24 (10 bytes), each byte changed by upstream at T+1, spi_end after the last byte → one CS-low window, 14 send_done pulses, no CS glitch between bytes.
3. Loopback with spi_miso tied to spi_mosi, data_send=8'hA5 → data_rec=8'hA5 with rec_done coincident with send_done.
4. spi_start pulsed mid-SHIFT and during GUARD → ignored; no extra byte; spi_cs_n unaffected.
5. sys_rst asserted at bit 4 → next edge spi_cs_n=1, spi_sclk=0, no send_done; a following spi_start with 8'h05 completes normally.
6. CLK_DIV=1; spi_end pulsed mid-byte (end_pend path) → byte completes, 17-cycle byte period, spi_cs_n high 1 cycle after HOLD starts.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI flash driver slice.
// Holds the driver FSM state type, W25Qxx opcodes used by the upstream
// command controllers, and the default timing parameters.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        HOLD,
        GUARD
    } spi_drv_state_t;

    // W25Qxx opcodes
    localparam logic [7:0] WR_EN        = 8'h06;
    localparam logic [7:0] PAGE_PROGRAM = 8'h02;
    localparam logic [7:0] READ_DATA    = 8'h03;
    localparam logic [7:0] READ_SR1     = 8'h05;
    localparam logic [7:0] SECTOR_ERASE = 8'h20;

    // 2 sys_clk per SCLK half-period -> 12.5 MHz SCLK from 50 MHz
    localparam int unsigned DEFAULT_CLK_DIV     = 2;
    localparam int unsigned DEFAULT_CS_MIN_HIGH = 3;

endpackage

// File: rtl/spi_sclk_div.sv
// SCLK half-period divider.
// Counts sys_clk cycles while run is high and flags the end of each
// half-period as a rise or fall enable depending on the current SCLK level.
// Ports:
//   sys_clk, sys_rst   clock, synchronous active-high reset
//   run                counter enable; counter is held at 0 when low
//   sclk_level         current registered SCLK level
//   rise_en, fall_en   one-cycle enables: toggle SCLK high / low at this edge
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic sclk_level,
    output logic rise_en,
    output logic fall_en
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       tick;

    always_comb begin
        tick      = run && (div_cnt_q == DIV_LAST);
        div_cnt_d = div_cnt_q + 8'd1;
        if (!run || tick) begin
            div_cnt_d = '0;
        end
    end

    assign rise_en = tick & ~sclk_level;
    assign fall_en = tick & sclk_level;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_drv.sv
// Byte-level SPI master, mode 0, MSB first, for W25Qxx flash.
// Upstream controllers open a transaction with spi_start, feed one byte per
// send_done via data_send, and close it with spi_end. MISO is captured on the
// same SCLK rising edges so read-side controllers can share this driver.
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   spi_start, spi_end    open / close transaction strobes
//   data_send             byte to transmit (sampled at start and at GAP)
//   send_done, rec_done   one-cycle pulse per completed byte
//   data_rec              byte captured from spi_miso
//   spi_busy              transaction in progress incl. CS guard time
//   spi_cs_n, spi_sclk, spi_mosi, spi_miso   flash pins
module spi_master_drv
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int unsigned CS_MIN_HIGH = DEFAULT_CS_MIN_HIGH
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       spi_start,
    input  logic       spi_end,
    input  logic [7:0] data_send,
    output logic       send_done,
    output logic [7:0] data_rec,
    output logic       rec_done,
    output logic       spi_busy,
    output logic       spi_cs_n,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    localparam logic [7:0] GUARD_LAST = 8'(CS_MIN_HIGH - 1);

    spi_drv_state_t state_q, state_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] data_rec_q, data_rec_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] guard_cnt_q, guard_cnt_d;
    logic       end_pend_q, end_pend_d;
    logic       cs_n_q, cs_n_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       div_run, rise_en, fall_en;

    // During the send_done cycle the FSM still sits in SHIFT with the
    // divider stopped, so GAP lands on the cycle after send_done.
    assign div_run = (state_q == SETUP) || (state_q == HOLD) ||
                     ((state_q == SHIFT) && !done_q);

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .run        (div_run),
        .sclk_level (sclk_q),
        .rise_en    (rise_en),
        .fall_en    (fall_en)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        data_rec_d  = data_rec_q;
        bit_cnt_d   = bit_cnt_q;
        guard_cnt_d = guard_cnt_q;
        end_pend_d  = end_pend_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (spi_start) begin
                    state_d    = SETUP;
                    tx_d       = data_send;
                    mosi_d     = data_send[7];
                    cs_n_d     = 1'b0;
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    end_pend_d = end_pend_q | spi_end;
                end
            end
            SETUP: begin
                if (spi_end) end_pend_d = 1'b1;
                if (rise_en) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], spi_miso};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (spi_end) end_pend_d = 1'b1;
                if (done_q) begin
                    state_d = GAP;
                end else if (fall_en) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q != 3'd7) begin
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end else if (rise_en) begin
                    // bit_cnt wraps to 0 on the 8th fall; a rise seen with
                    // bit_cnt 0 marks the end of the last low half-period.
                    if (bit_cnt_q == 3'd0) begin
                        done_d     = 1'b1;
                        data_rec_d = rx_q;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], spi_miso};
                    end
                end
            end
            GAP: begin
                if (spi_end || end_pend_q) begin
                    state_d    = HOLD;
                    end_pend_d = 1'b0;
                end else begin
                    tx_d      = data_send;
                    mosi_d    = data_send[7];
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            HOLD: begin
                if (spi_end) end_pend_d = 1'b1;
                if (rise_en) begin
                    cs_n_d      = 1'b1;
                    guard_cnt_d = '0;
                    state_d     = GUARD;
                end
            end
            GUARD: begin
                if (guard_cnt_q == GUARD_LAST) begin
                    guard_cnt_d = '0;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            tx_q        <= '0;
            rx_q        <= '0;
            data_rec_q  <= '0;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            end_pend_q  <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            data_rec_q  <= data_rec_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            end_pend_q  <= end_pend_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign send_done = done_q;
    assign rec_done  = done_q;
    assign data_rec  = data_rec_q;
    assign spi_busy  = busy_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_drv.sv
// Directed bench for spi_master_drv: default-divider instance plus a
// CLK_DIV=1 instance selected through an output mux.
module tb_spi_master_drv;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       spi_start = 1'b0;
    logic       spi_end = 1'b0;
    logic [7:0] data_send = 8'h00;
    logic       miso_drv = 1'b0;
    logic       loop = 1'b0;
    logic       sel = 1'b0;
    logic       miso;

    logic       d0_send_done, d0_rec_done, d0_busy, d0_cs_n, d0_sclk, d0_mosi;
    logic       d1_send_done, d1_rec_done, d1_busy, d1_cs_n, d1_sclk, d1_mosi;
    logic [7:0] d0_data_rec, d1_data_rec;
    logic       start0, start1, end0, end1;

    logic       o_send_done, o_rec_done, o_busy, o_cs_n, o_sclk, o_mosi;
    logic [7:0] o_data_rec;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    assign start0 = spi_start & ~sel;
    assign start1 = spi_start & sel;
    assign end0   = spi_end & ~sel;
    assign end1   = spi_end & sel;

    assign o_send_done = sel ? d1_send_done : d0_send_done;
    assign o_rec_done  = sel ? d1_rec_done  : d0_rec_done;
    assign o_busy      = sel ? d1_busy      : d0_busy;
    assign o_cs_n      = sel ? d1_cs_n      : d0_cs_n;
    assign o_sclk      = sel ? d1_sclk      : d0_sclk;
    assign o_mosi      = sel ? d1_mosi      : d0_mosi;
    assign o_data_rec  = sel ? d1_data_rec  : d0_data_rec;
    assign miso        = loop ? o_mosi : miso_drv;

    spi_master_drv u_dut0 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .spi_start (start0),
        .spi_end   (end0),
        .data_send (data_send),
        .send_done (d0_send_done),
        .data_rec  (d0_data_rec),
        .rec_done  (d0_rec_done),
        .spi_busy  (d0_busy),
        .spi_cs_n  (d0_cs_n),
        .spi_sclk  (d0_sclk),
        .spi_mosi  (d0_mosi),
        .spi_miso  (miso)
    );

    spi_master_drv #(
        .CLK_DIV (1)
    ) u_dut1 (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .spi_start (start1),
        .spi_end   (end1),
        .data_send (data_send),
        .send_done (d1_send_done),
        .data_rec  (d1_data_rec),
        .rec_done  (d1_rec_done),
        .spi_busy  (d1_busy),
        .spi_cs_n  (d1_cs_n),
        .spi_sclk  (d1_sclk),
        .spi_mosi  (d1_mosi),
        .spi_miso  (miso)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called in the SETUP-entry cycle; returns in the send_done cycle.
    task automatic run_byte(input int start_at, input int end_at, output int n,
                            output logic [7:0] got, output int rises, output int glitch);
        logic prev;
        prev   = o_sclk;
        n      = 0;
        got    = 8'h00;
        rises  = 0;
        glitch = 0;
        while (n < 200) begin
            step();
            n++;
            spi_start = (n == start_at);
            spi_end   = (n == end_at);
            if (o_cs_n !== 1'b0) glitch++;
            if (o_send_done === 1'b1) break;
            if (o_sclk === 1'b1 && prev === 1'b0) begin
                got = {got[6:0], o_mosi};
                rises++;
            end
            prev = o_sclk;
        end
        spi_start = 1'b0;
        spi_end   = 1'b0;
    endtask

    // Called in the send_done cycle T of the default-divider instance.
    task automatic close_txn(input bit do_end, input bit poke_start);
        step();                                   // T+1 GAP
        check("gap_send_done", o_send_done, 0);
        spi_end = do_end;
        step();                                   // T+2 HOLD
        spi_end = 1'b0;
        check("hold_cs_n_a", o_cs_n, 0);
        step();                                   // T+3
        check("hold_cs_n_b", o_cs_n, 0);
        check("hold_sclk", o_sclk, 0);
        step();                                   // T+4 GUARD
        check("guard_cs_n", o_cs_n, 1);
        check("guard_busy_a", o_busy, 1);
        if (poke_start) begin
            spi_start = 1'b1;
            data_send = 8'hFF;
        end
        step();                                   // T+5
        spi_start = 1'b0;
        step();                                   // T+6
        check("guard_busy_b", o_busy, 1);
        step();                                   // T+7
        check("idle_busy", o_busy, 0);
        repeat (3) step();
        check("idle_cs_n", o_cs_n, 1);
        check("idle_busy_late", o_busy, 0);
    endtask

    logic [7:0] pp_bytes [14] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08,
                                  8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};

    initial begin
        int         n, rises, glitch, done_cnt, glitch_sum, cs_low;
        logic [7:0] got;

        // Reset values
        repeat (3) step();
        check("rst_cs_n", o_cs_n, 1);
        check("rst_sclk", o_sclk, 0);
        check("rst_mosi", o_mosi, 0);
        check("rst_send_done", o_send_done, 0);
        check("rst_rec_done", o_rec_done, 0);
        check("rst_data_rec", o_data_rec, 8'h00);
        check("rst_busy", o_busy, 0);
        sys_rst = 1'b0;
        step();

        // 1: single WR_EN byte, MISO held high
        miso_drv  = 1'b1;
        data_send = 8'h06;
        spi_start = 1'b1;
        step();
        spi_start = 1'b0;
        data_send = 8'hFF;
        check("t1_cs_n", o_cs_n, 0);
        check("t1_mosi_bit7", o_mosi, 0);
        check("t1_busy", o_busy, 1);
        run_byte(0, 0, n, got, rises, glitch);
        check("t1_period", n, 34);
        check("t1_mosi_byte", got, 8'h06);
        check("t1_rises", rises, 8);
        check("t1_data_rec", o_data_rec, 8'hFF);
        check("t1_rec_done", o_rec_done, 1);
        close_txn(1'b1, 1'b0);
        miso_drv = 1'b0;

        // 2: page-program stream of 14 bytes in one CS window
        done_cnt   = 0;
        glitch_sum = 0;
        data_send  = pp_bytes[0];
        spi_start  = 1'b1;
        step();
        spi_start  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            data_send = 8'hEE;                    // outside sample cycles: no effect
            run_byte(0, 0, n, got, rises, glitch);
            if (o_send_done === 1'b1) done_cnt++;
            glitch_sum += glitch;
            check("t2_byte", got, pp_bytes[i]);
            if (i < 13) begin
                step();                           // T+1 GAP
                if (o_cs_n !== 1'b0) glitch_sum++;
                data_send = pp_bytes[i + 1];
                step();                           // T+2 SETUP
                if (o_cs_n !== 1'b0) glitch_sum++;
            end
        end
        check("t2_done_cnt", done_cnt, 14);
        check("t2_cs_glitch", glitch_sum, 0);
        close_txn(1'b1, 1'b0);

        // 3: loopback
        loop      = 1'b1;
        data_send = 8'hA5;
        spi_start = 1'b1;
        step();
        spi_start = 1'b0;
        run_byte(0, 0, n, got, rises, glitch);
        check("t3_data_rec", o_data_rec, 8'hA5);
        check("t3_rec_done", o_rec_done, 1);
        check("t3_send_done", o_send_done, 1);
        close_txn(1'b1, 1'b0);
        loop = 1'b0;

        // 4: starts mid-SHIFT and during GUARD ignored
        data_send = 8'h20;
        spi_start = 1'b1;
        step();
        spi_start = 1'b0;
        run_byte(10, 0, n, got, rises, glitch);
        check("t4_period", n, 34);
        check("t4_byte", got, 8'h20);
        check("t4_glitch", glitch, 0);
        close_txn(1'b1, 1'b1);

        // start and end together in IDLE: single-byte transaction
        data_send = 8'h9C;
        spi_start = 1'b1;
        spi_end   = 1'b1;
        step();
        spi_start = 1'b0;
        spi_end   = 1'b0;
        run_byte(0, 0, n, got, rises, glitch);
        check("se_period", n, 34);
        check("se_byte", got, 8'h9C);
        close_txn(1'b0, 1'b0);

        // 5: reset at bit 4
        data_send = 8'h5A;
        spi_start = 1'b1;
        step();
        spi_start = 1'b0;
        repeat (18) step();
        check("t5_sclk_bit4", o_sclk, 1);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        check("t5_cs_n", o_cs_n, 1);
        check("t5_sclk", o_sclk, 0);
        check("t5_busy", o_busy, 0);
        done_cnt = 0;
        cs_low   = 0;
        for (int i = 0; i < 40; i++) begin
            if (o_send_done !== 1'b0) done_cnt++;
            if (o_cs_n !== 1'b1) cs_low++;
            step();
        end
        check("t5_no_done", done_cnt, 0);
        check("t5_cs_idle", cs_low, 0);
        data_send = 8'h05;
        spi_start = 1'b1;
        step();
        spi_start = 1'b0;
        run_byte(0, 0, n, got, rises, glitch);
        check("t5_period", n, 34);
        check("t5_byte", got, 8'h05);
        close_txn(1'b1, 1'b0);

        // 6: CLK_DIV=1, spi_end mid-byte
        sel       = 1'b1;
        step();
        data_send = 8'h3C;
        spi_start = 1'b1;
        step();
        spi_start = 1'b0;
        check("t6_cs_n", o_cs_n, 0);
        run_byte(0, 5, n, got, rises, glitch);
        check("t6_period", n, 17);
        check("t6_byte", got, 8'h3C);
        check("t6_rises", rises, 8);
        step();                                   // T+1 GAP
        step();                                   // T+2 HOLD
        check("t6_hold_cs_n", o_cs_n, 0);
        step();                                   // T+3
        check("t6_guard_cs_n", o_cs_n, 1);
        check("t6_guard_busy", o_busy, 1);
        step();
        step();                                   // T+5
        check("t6_guard_busy_end", o_busy, 1);
        step();                                   // T+6
        check("t6_idle_busy", o_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
